alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder.
- Computes the result on two XLEN operands and registers it with a valid/ready handshake toward the memory/writeback stage.
- Uses a 2-entry skid buffer so in_ready is a pure register output, which breaks the ready path from downstream.
- Supports pipeline flush on branch redirect.

Parameters:
- XLEN, 32, operand/result width in bits.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  upstream holds a valid operation.
- in_ready  output  1  stage can accept; registered.
- alu_ctrl  input  4  ALU control code from the decoder.
- op_a  input  XLEN  operand A.
- op_b  input  XLEN  operand B.
- rd_addr  input  RD_W  destination register tag, passed through.
- flush  input  1  discard all held entries.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_result  output  XLEN  ALU result.
- out_zero  output  1  out_result == 0 (branch compare).
- out_rd_addr  output  RD_W  tag of out_result.
- out_ctrl_err  output  1  the entry carried an unsupported alu_ctrl code.

Behaviour:
- Opcodes:
  - 0000: AND
  - 0001: OR
  - 0010: ADD, modulo 2^XLEN, carry dropped
  - 0110: SUB, op_a - op_b, modulo 2^XLEN
  - Any other code: result 0, zero=1, ctrl_err=1.
- Result is computed combinationally at the input and stored with its entry. Latency is 1 cycle from accept (in_valid & in_ready) to out_valid.
- Storage:
  - main register drives the out_* ports.
  - skid register holds one overflow entry.
- States:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid.
  - TWO: main and skid valid.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + out_ready -> ONE; main is replaced by the new entry.
  - ONE + accept + !out_ready -> TWO; new entry goes to skid.
  - ONE + !accept + out_ready -> EMPTY.
  - TWO + out_ready -> ONE; skid moves to main.
  - In TWO, in_ready=0, so there is no accept.
- in_ready = !skid_valid, registered. It is 1 in EMPTY and ONE, and 0 in TWO.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- out_* fields hold stable while out_valid & !out_ready.
- flush:
  - Next cycle is EMPTY and in_ready=1.
  - An accept in the same cycle is discarded; flush has priority.
  - An out_ready handshake in the flush cycle still completes for the current main entry.
- Reset (rst high at a clock edge), from any state including TWO:
  - out_valid=0, in_ready=1.
  - out_result=0, out_zero=0, out_rd_addr=0, out_ctrl_err=0.
  - skid cleared.
  - Inputs are ignored in the reset cycle.
- When out_valid=0, the out_* data ports hold their last value. They are don't-care for checking.

Optional Feature:
- Macro: ALU_SLT_EN.
- Defined:
  - Code 0111 = SLT: signed op_a < op_b gives result 1, otherwise 0; ctrl_err=0.
  - Code 1000 = SLTU: unsigned compare.
- Undefined: 0111 and 1000 are unsupported codes (result 0, ctrl_err=1).

Decomposition:
- Package alu_pkg holds:
  - localparams ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_SLTU=4'b1000.
  - Entry typedef: result, zero, rd_addr, ctrl_err.
- Sub-module alu_core: purely combinational op decode and arithmetic. It is instantiated once; the stage wraps it with the skid/handshake logic.

Test Plan:
- ADD: alu_ctrl=0010, a=5, b=7, rd=3, out_ready=1 -> next cycle out_valid=1, result=12, zero=0, rd=3.
- SUB and wrap:
  - 0110, a=9, b=9 -> result=0, zero=1.
  - 0110, a=0, b=1 -> result=0xFFFFFFFF.
  - 0010, a=0xFFFFFFFF, b=1 -> result=0, zero=1.
- Backpressure: out_ready=0, offer ops A (rd1), B (rd2), C (rd3) on consecutive cycles -> A and B accepted, in_ready=0 from the cycle after B, C held. Raise out_ready -> outputs appear in order A, B, C with no loss.
- Flush in TWO with in_valid=1 simultaneously -> next cycle out_valid=0, in_ready=1, the offered op is absent from the output stream.
- Unsupported code 4'b1111, a=3, b=4 -> result=0, zero=1, ctrl_err=1. With ALU_SLT_EN: 0111, a=-1, b=1 -> 1; 1000, a=-1, b=1 -> 0.
- Reset asserted while in TWO -> next cycle all outputs 0 and in_ready=1; a subsequent ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and the stored entry type for the execute-stage ALU.
package alu_pkg;

  localparam int ENTRY_XLEN = 32;
  localparam int ENTRY_RD_W = 5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] result;
    logic                  zero;
    logic [ENTRY_RD_W-1:0] rd_addr;
    logic                  ctrl_err;
  } entry_t;

endpackage

// File: rtl/alu_core.sv
// Combinational opcode decode and arithmetic.
// Optional macro ALU_SLT_EN adds signed/unsigned set-less-than (codes 0111/1000).
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            ctrl_err
);

  // Select the operation; unsupported codes yield 0 and flag an error.
  always_comb begin
    result   = '0;
    ctrl_err = 1'b0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
`ifdef ALU_SLT_EN
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
`endif
      default: ctrl_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with a 2-entry skid buffer and flush support.
// in_ready is a flop so the upstream ready path never sees out_ready.
// Optional macro ALU_SLT_EN (passed through to alu_core) enables SLT/SLTU.
//
// state | meaning
// EMPTY | main invalid, skid invalid
// ONE   | main valid, skid invalid
// TWO   | main and skid valid, in_ready low
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [RD_W-1:0] rd_addr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic [RD_W-1:0] out_rd_addr,
  output logic            out_ctrl_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  entry_t          main_q, skid_q, new_entry;
  logic            in_ready_q;
  logic            accept;
  logic            load_main, load_skid, skid_to_main;
  logic [XLEN-1:0] core_result;
  logic            core_err;

  alu_core #(.XLEN(XLEN)) u_core (
    .ctrl     (alu_ctrl),
    .a        (op_a),
    .b        (op_b),
    .result   (core_result),
    .ctrl_err (core_err)
  );

  // Package the freshly computed result into a storable entry.
  always_comb begin
    new_entry          = '0;
    new_entry.result   = core_result;
    new_entry.zero     = (core_result == '0);
    new_entry.rd_addr  = rd_addr;
    new_entry.ctrl_err = core_err;
  end

  // Flush wins over a same-cycle accept, so the offered op is dropped.
  assign accept = in_valid & in_ready_q & ~flush;

  // Next-state and storage steering.
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && out_ready) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_ready) begin
          state_d      = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d      = EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  // State, registered in_ready, and the two entry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      if (load_main) begin
        main_q <= new_entry;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= new_entry;
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != EMPTY);
  assign out_result   = main_q.result;
  assign out_zero     = main_q.zero;
  assign out_rd_addr  = main_q.rd_addr;
  assign out_ctrl_err = main_q.ctrl_err;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed, table-driven bench for alu_exec_stage.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd_addr;
  logic        out_ctrl_err;

  int n_total = 0;
  int n_pass  = 0;

  alu_exec_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_ctrl     (alu_ctrl),
    .op_a         (op_a),
    .op_b         (op_b),
    .rd_addr      (rd_addr),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_rd_addr  (out_rd_addr),
    .out_ctrl_err (out_ctrl_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    rd_addr  = rd;
  endtask

  task automatic check_out(input string name, input logic [31:0] res, input logic [4:0] rd);
    check({name, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({name, ".result"}, out_result, res);
    check({name, ".rd"}, {27'd0, out_rd_addr}, {27'd0, rd});
  endtask

  initial begin
    vecs[0] = '{4'b0010, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0, 1'b0};
    vecs[1] = '{4'b0110, 32'd9, 32'd9, 5'd4, 32'd0, 1'b1, 1'b0};
    vecs[2] = '{4'b0110, 32'd0, 32'd1, 5'd5, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[3] = '{4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd0, 1'b1, 1'b0};
    vecs[4] = '{4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd7, 32'h0000_F000, 1'b0, 1'b0};
    vecs[5] = '{4'b0001, 32'h0000_F0F0, 32'h0000_0F0F, 5'd8, 32'h0000_FFFF, 1'b0, 1'b0};
    vecs[6] = '{4'b1111, 32'd3, 32'd4, 5'd9, 32'd0, 1'b1, 1'b1};
    vecs[7] = '{4'b0110, 32'h10, 32'd3, 5'd10, 32'h0D, 1'b0, 1'b0};
`ifdef ALU_SLT_EN
    vecs[8] = '{4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd11, 32'd1, 1'b0, 1'b0};
    vecs[9] = '{4'b1000, 32'hFFFF_FFFF, 32'd1, 5'd12, 32'd0, 1'b1, 1'b0};
`else
    vecs[8] = '{4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd11, 32'd0, 1'b1, 1'b1};
    vecs[9] = '{4'b1000, 32'hFFFF_FFFF, 32'd1, 5'd12, 32'd0, 1'b1, 1'b1};
`endif

    rst = 1'b1; in_valid = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0;
    rd_addr = '0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back vectors with downstream always ready: 1-cycle latency.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].rd);
      step();
      check($sformatf("vec%0d.valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d.result", i), out_result, vecs[i].res);
      check($sformatf("vec%0d.zero", i), {31'd0, out_zero}, {31'd0, vecs[i].zero});
      check($sformatf("vec%0d.rd", i), {27'd0, out_rd_addr}, {27'd0, vecs[i].rd});
      check($sformatf("vec%0d.err", i), {31'd0, out_ctrl_err}, {31'd0, vecs[i].err});
    end
    in_valid = 1'b0;
    step();
    check("drain.out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: A, B accepted, C held, then drained in order.
    out_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd1, 5'd1);
    step();
    check_out("bp.A0", 32'd2, 5'd1);
    check("bp.ready_after_A", {31'd0, in_ready}, 32'd1);
    drive(4'b0010, 32'd2, 32'd2, 5'd2);
    step();
    check("bp.ready_after_B", {31'd0, in_ready}, 32'd0);
    check_out("bp.A1", 32'd2, 5'd1);
    drive(4'b0010, 32'd3, 32'd3, 5'd3);
    step();
    check("bp.ready_held", {31'd0, in_ready}, 32'd0);
    check_out("bp.A_stable", 32'd2, 5'd1);
    out_ready = 1'b1;
    step();
    check_out("bp.B", 32'd4, 5'd2);
    check("bp.ready_reopen", {31'd0, in_ready}, 32'd1);
    step();
    check_out("bp.C", 32'd6, 5'd3);
    in_valid = 1'b0;
    step();
    check("bp.empty", {31'd0, out_valid}, 32'd0);

    // Flush in TWO with an op offered at the same time.
    out_ready = 1'b0;
    drive(4'b0010, 32'd4, 32'd0, 5'd4);
    step();
    drive(4'b0010, 32'd5, 32'd0, 5'd5);
    step();
    check("fl2.in_ready_two", {31'd0, in_ready}, 32'd0);
    drive(4'b0010, 32'd6, 32'd0, 5'd6);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl2.out_valid", {31'd0, out_valid}, 32'd0);
    check("fl2.in_ready", {31'd0, in_ready}, 32'd1);

    // Flush in ONE with a same-cycle accept: the accepted op must vanish.
    drive(4'b0010, 32'd7, 32'd0, 5'd7);
    step();
    check_out("fl1.pre", 32'd7, 5'd7);
    drive(4'b0010, 32'd8, 32'd0, 5'd8);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl1.out_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("fl1.no_ghost", {31'd0, out_valid}, 32'd0);

    // Reset while in TWO, then a normal ADD.
    out_ready = 1'b0;
    drive(4'b0010, 32'd9, 32'd1, 5'd9);
    step();
    drive(4'b0010, 32'd10, 32'd1, 5'd10);
    step();
    check("rst2.in_two", {31'd0, in_ready}, 32'd0);
    drive(4'b0110, 32'd3, 32'd1, 5'd11);
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst2.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst2.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst2.result", out_result, 32'd0);
    check("rst2.zero", {31'd0, out_zero}, 32'd0);
    check("rst2.rd", {27'd0, out_rd_addr}, 32'd0);
    check("rst2.err", {31'd0, out_ctrl_err}, 32'd0);
    out_ready = 1'b1;
    drive(4'b0010, 32'd20, 32'd22, 5'd7);
    step();
    in_valid = 1'b0;
    check_out("rst2.add", 32'd42, 5'd7);
    step();
    check("rst2.drained", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
